branch_format_decoder: RTL and testbench

//  Decode-2 unit for every POWER ISA 3.0B branch: I-form b (op 18), B-form bc (op 16) and
//  XL-form bclr/bcctr/bctar (op 19, XO 16/528/560). Extracts operands, computes the immediate

---
 rtl/branch_decode_pkg.sv | 41 ++++
 rtl/decode_out_fifo.sv | 54 +++++
 rtl/branch_format_decoder.sv | 142 ++++++++++++++
 tb/tb_branch_format_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/branch_decode_pkg.sv
// branch_decode_pkg: shared constants and queue-entry layout for the branch decoder
package branch_decode_pkg;
    localparam int addressWidth            = 64;
    localparam int instructionWidth        = 32;
    localparam int PidSize                 = 20;
    localparam int TidSize                 = 16;
    localparam int instructionCounterWidth = 64;
    localparam int instMinIdWidth          = 7;

    localparam logic [5:0] OP_B  = 6'd18;
    localparam logic [5:0] OP_BC = 6'd16;
    localparam logic [5:0] OP_XL = 6'd19;

    localparam logic [9:0] XO_BCLR  = 10'd16;
    localparam logic [9:0] XO_BCCTR = 10'd528;
    localparam logic [9:0] XO_BCTAR = 10'd560;

    localparam logic [2:0] FU_NONE   = 3'd0;
    localparam logic [2:0] FU_BRANCH = 3'd6;

    typedef struct packed {
        logic [5:0]                         opcode;
        logic [2:0]                         fu;
        logic [instructionCounterWidth-1:0] maj_id;
        logic [instMinIdWidth-1:0]          min_id;
        logic [PidSize-1:0]                 pid;
        logic [TidSize-1:0]                 tid;
        logic                               is64;
        logic [4:0]                         bo;
        logic [4:0]                         bi;
        logic [1:0]                         bh;
        logic [addressWidth-1:0]            target;
        logic                               target_valid;
        logic                               ctr_dec;
        logic                               lr_write;
        logic                               lr_read;
        logic                               ctr_read;
        logic                               tar_read;
        logic                               illegal;
    } branch_entry_t;
endpackage

// File: rtl/decode_out_fifo.sv
// decode_out_fifo: generic synchronous FIFO with async reset and sync flush
module decode_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q];

    // storage, pointers and occupancy; reset also clears storage so outputs read 0
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= nxt(wr_q);
            end
            if (do_pop) rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/branch_format_decoder.sv
// branch_format_decoder: decodes I/B/XL-form branches into a valid/ready output queue
module branch_format_decoder
    import branch_decode_pkg::*;
#(
    parameter int         OUT_DEPTH    = 2,
    parameter int         CNT_W        = 16,
    parameter logic [2:0] BranchUnitID = FU_BRANCH
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [instructionWidth-1:0]        instruction_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 instructionPid_i,
    input  logic [TidSize-1:0]                 instructionTid_i,
    input  logic [instructionCounterWidth-1:0] instructionMajId_i,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [5:0]                         opcode_o,
    output logic [2:0]                         functionalUnitType_o,
    output logic [instructionCounterWidth-1:0] instMajId_o,
    output logic [instMinIdWidth-1:0]          instMinId_o,
    output logic [PidSize-1:0]                 instPid_o,
    output logic [TidSize-1:0]                 instTid_o,
    output logic                               is64Bit_o,
    output logic [4:0]                         bo_o,
    output logic [4:0]                         bi_o,
    output logic [1:0]                         bh_o,
    output logic [addressWidth-1:0]            target_o,
    output logic                               targetValid_o,
    output logic                               ctrDec_o,
    output logic                               lrWrite_o,
    output logic                               lrRead_o,
    output logic                               ctrRead_o,
    output logic                               tarRead_o,
    output logic                               illegal_o,
    output logic [CNT_W-1:0]                   decodedCount_o,
    output logic [CNT_W-1:0]                   illegalCount_o
);
    branch_entry_t           ent, head;
    logic [5:0]              op;
    logic [9:0]              xo;
    logic [4:0]              bo_f;
    logic                    is_b, is_bc, is_xl, is_bclr, is_bcctr, is_bctar, bad;
    logic [addressWidth-1:0] imm, sum;
    logic                    accept, fifo_full, fifo_empty;
    logic [CNT_W-1:0]        dec_q, dec_d, ill_q, ill_d;

    // instruction bit k (MSB-first numbering) lives at instruction_i[31-k]
    assign op       = instruction_i[31:26];
    assign xo       = instruction_i[10:1];
    assign bo_f     = instruction_i[25:21];
    assign is_b     = op == OP_B;
    assign is_bc    = op == OP_BC;
    assign is_xl    = op == OP_XL;
    assign is_bclr  = is_xl && xo == XO_BCLR;
    assign is_bcctr = is_xl && xo == XO_BCCTR;
    assign is_bctar = is_xl && xo == XO_BCTAR;
    assign bad      = !(is_b || is_bc || is_xl)
                    || (is_xl && !(is_bclr || is_bcctr || is_bctar))
                    || (is_bcctr && !bo_f[2])
                    || (is_xl && instruction_i[15:13] != 3'b000);
    assign imm      = is_b ? {{38{instruction_i[25]}}, instruction_i[25:2], 2'b00}
                           : {{48{instruction_i[15]}}, instruction_i[15:2], 2'b00};
    assign sum      = instruction_i[1] ? imm : instructionAddress_i + imm;

    // build the queue entry for the instruction currently on the input
    always_comb begin
        ent              = '0;
        ent.opcode       = op;
        ent.fu           = bad ? FU_NONE : BranchUnitID;
        ent.maj_id       = instructionMajId_i;
        ent.pid          = instructionPid_i;
        ent.tid          = instructionTid_i;
        ent.is64         = is64Bit_i;
        ent.bo           = is_b ? 5'b10100 : (is_bc || is_xl) ? bo_f : 5'b0;
        ent.bi           = (is_bc || is_xl) ? instruction_i[20:16] : 5'b0;
        ent.bh           = is_xl ? instruction_i[12:11] : 2'b0;
        ent.target       = !(is_b || is_bc) ? '0 : is64Bit_i ? sum : {32'b0, sum[31:0]};
        ent.target_valid = is_b || is_bc;
        ent.ctr_dec      = !bad && (is_bc || (is_xl && !is_bcctr)) && !bo_f[2];
        ent.lr_write     = !bad && instruction_i[0];
        ent.lr_read      = !bad && is_bclr;
        ent.ctr_read     = !bad && is_bcctr;
        ent.tar_read     = !bad && is_bctar;
        ent.illegal      = bad;
    end

    assign ready_o = !fifo_full;
    assign valid_o = !fifo_empty;
    assign accept  = valid_i && ready_o && !flush_i;

    decode_out_fifo #(.WIDTH($bits(branch_entry_t)), .DEPTH(OUT_DEPTH)) u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .push_i  (accept),
        .pop_i   (valid_o && ready_i),
        .data_i  (ent),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign dec_d = (accept && !bad && dec_q != '1) ? dec_q + 1'b1 : dec_q;
    assign ill_d = (accept && bad && ill_q != '1) ? ill_q + 1'b1 : ill_q;

    // saturating statistics counters, untouched by flush
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            dec_q <= '0;
            ill_q <= '0;
        end else begin
            dec_q <= dec_d;
            ill_q <= ill_d;
        end
    end

    assign opcode_o             = head.opcode;
    assign functionalUnitType_o = head.fu;
    assign instMajId_o          = head.maj_id;
    assign instMinId_o          = head.min_id;
    assign instPid_o            = head.pid;
    assign instTid_o            = head.tid;
    assign is64Bit_o            = head.is64;
    assign bo_o                 = head.bo;
    assign bi_o                 = head.bi;
    assign bh_o                 = head.bh;
    assign target_o             = head.target;
    assign targetValid_o        = head.target_valid;
    assign ctrDec_o             = head.ctr_dec;
    assign lrWrite_o            = head.lr_write;
    assign lrRead_o             = head.lr_read;
    assign ctrRead_o            = head.ctr_read;
    assign tarRead_o            = head.tar_read;
    assign illegal_o            = head.illegal;
    assign decodedCount_o       = dec_q;
    assign illegalCount_o       = ill_q;
endmodule

// File: tb/tb_branch_format_decoder.sv
// tb_branch_format_decoder: directed self-checking bench for branch_format_decoder
module tb_branch_format_decoder;
    logic        clock_i = 0, reset_i = 1, flush_i = 0, valid_i = 0, ready_i = 1, is64Bit_i = 1;
    logic [31:0] instruction_i = 0;
    logic [63:0] instructionAddress_i = 0, instructionMajId_i = 64'h55;
    logic [19:0] instructionPid_i = 20'hABCDE;
    logic [15:0] instructionTid_i = 16'h1234;
    logic        ready_o, valid_o, is64Bit_o, targetValid_o, ctrDec_o, lrWrite_o;
    logic        lrRead_o, ctrRead_o, tarRead_o, illegal_o;
    logic [5:0]  opcode_o;
    logic [2:0]  functionalUnitType_o;
    logic [63:0] instMajId_o, target_o;
    logic [6:0]  instMinId_o;
    logic [19:0] instPid_o;
    logic [15:0] instTid_o;
    logic [4:0]  bo_o, bi_o;
    logic [1:0]  bh_o;
    logic [15:0] decodedCount_o, illegalCount_o;
    int          checks = 0, errors = 0;

    branch_format_decoder dut (
        .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .instruction_i(instruction_i),
        .instructionAddress_i(instructionAddress_i), .is64Bit_i(is64Bit_i),
        .instructionPid_i(instructionPid_i), .instructionTid_i(instructionTid_i),
        .instructionMajId_i(instructionMajId_i), .valid_o(valid_o), .ready_i(ready_i),
        .opcode_o(opcode_o), .functionalUnitType_o(functionalUnitType_o),
        .instMajId_o(instMajId_o), .instMinId_o(instMinId_o), .instPid_o(instPid_o),
        .instTid_o(instTid_o), .is64Bit_o(is64Bit_o), .bo_o(bo_o), .bi_o(bi_o), .bh_o(bh_o),
        .target_o(target_o), .targetValid_o(targetValid_o), .ctrDec_o(ctrDec_o),
        .lrWrite_o(lrWrite_o), .lrRead_o(lrRead_o), .ctrRead_o(ctrRead_o),
        .tarRead_o(tarRead_o), .illegal_o(illegal_o), .decodedCount_o(decodedCount_o),
        .illegalCount_o(illegalCount_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [63:0] addr, input logic m64);
        valid_i              = 1;
        instruction_i        = ins;
        instructionAddress_i = addr;
        is64Bit_i            = m64;
    endtask

    task automatic send(input logic [31:0] ins, input logic [63:0] addr, input logic m64);
        drive(ins, addr, m64);
        step();
        valid_i = 0;
    endtask

    initial begin
        step();
        chk("rst_valid", valid_o, 0);
        chk("rst_target", target_o, 0);
        chk("rst_bo", bo_o, 0);
        chk("rst_dec_cnt", decodedCount_o, 0);
        chk("rst_ill_cnt", illegalCount_o, 0);
        reset_i = 0;
        step();
        chk("rst_ready", ready_o, 1);

        drive(32'h48000010, 64'h1000, 1);
        chk("no_bypass", valid_o, 0);
        step();
        valid_i = 0;
        chk("b_valid", valid_o, 1);
        chk("b_target", target_o, 64'h1010);
        chk("b_tvalid", targetValid_o, 1);
        chk("b_lrw", lrWrite_o, 0);
        chk("b_bo", bo_o, 5'b10100);
        chk("b_fu", functionalUnitType_o, 6);
        chk("b_opc", opcode_o, 18);
        chk("b_pid", instPid_o, 20'hABCDE);
        chk("b_tid", instTid_o, 16'h1234);
        chk("b_maj", instMajId_o, 64'h55);
        chk("b_min", instMinId_o, 0);

        send(32'h48000013, 64'h1000, 1);
        chk("ba_target", target_o, 64'h10);
        chk("ba_lrw", lrWrite_o, 1);

        send(32'h4200FFF8, 64'h2000, 1);
        chk("bc_bo", bo_o, 16);
        chk("bc_bi", bi_o, 0);
        chk("bc_target", target_o, 64'h1FF8);
        chk("bc_ctrdec", ctrDec_o, 1);

        send(32'h4E800020, 64'h3000, 1);
        chk("bclr_lrr", lrRead_o, 1);
        chk("bclr_ctrdec", ctrDec_o, 0);
        chk("bclr_tvalid", targetValid_o, 0);
        chk("bclr_target", target_o, 0);

        send(32'h4E800420, 64'h3000, 1);
        chk("bcctr_ctrr", ctrRead_o, 1);
        chk("bcctr_lrr", lrRead_o, 0);
        chk("bcctr_ill", illegal_o, 0);

        send(32'h4C000420, 64'h3000, 1);
        chk("bad_ill", illegal_o, 1);
        chk("bad_fu", functionalUnitType_o, 0);
        chk("bad_ctrr", ctrRead_o, 0);
        chk("bad_ctrdec", ctrDec_o, 0);
        chk("bad_ill_cnt", illegalCount_o, 1);
        chk("bad_dec_cnt", decodedCount_o, 5);

        send(32'h48000020, 64'hFFFFFFF0, 0);
        chk("wrap_target", target_o, 64'h10);
        chk("wrap_is64", is64Bit_o, 0);

        send(32'h4E800460, 64'h3000, 1);
        chk("bctar_tarr", tarRead_o, 1);
        chk("bctar_ill", illegal_o, 0);

        send(32'h4E802020, 64'h3000, 1);
        chk("xlbits_ill", illegal_o, 1);
        chk("xlbits_lrr", lrRead_o, 0);
        chk("xlbits_ill_cnt", illegalCount_o, 2);
        chk("xlbits_dec_cnt", decodedCount_o, 7);

        step();
        chk("drain_valid", valid_o, 0);

        ready_i = 0;
        drive(32'h48000010, 64'h1000, 1);
        step();
        chk("bp_ready1", ready_o, 1);
        drive(32'h48000013, 64'h1000, 1);
        step();
        chk("bp_ready2", ready_o, 0);
        drive(32'h4200FFF8, 64'h2000, 1);
        step();
        chk("bp_hold_valid", valid_o, 1);
        chk("bp_hold_target", target_o, 64'h1010);
        ready_i = 1;
        step();
        chk("bp_second", target_o, 64'h10);
        chk("bp_ready_back", ready_o, 1);
        step();
        valid_i = 0;
        chk("bp_third", target_o, 64'h1FF8);
        chk("bp_third_bo", bo_o, 16);
        step();
        chk("bp_empty", valid_o, 0);
        chk("bp_dec_cnt", decodedCount_o, 10);

        ready_i = 0;
        send(32'h48000010, 64'h1000, 1);
        flush_i = 1;
        drive(32'h48000013, 64'h1000, 1);
        step();
        flush_i = 0;
        valid_i = 0;
        chk("fl1_valid", valid_o, 0);
        chk("fl1_dropped", decodedCount_o, 11);
        chk("fl1_ready", ready_o, 1);

        send(32'h48000010, 64'h1000, 1);
        send(32'h4C000420, 64'h1000, 1);
        chk("fl2_full", ready_o, 0);
        flush_i = 1;
        drive(32'h48000013, 64'h1000, 1);
        step();
        flush_i = 0;
        valid_i = 0;
        chk("fl2_valid", valid_o, 0);
        chk("fl2_dec_cnt", decodedCount_o, 12);
        chk("fl2_ill_cnt", illegalCount_o, 3);

        ready_i = 1;
        send(32'h48000010, 64'h1000, 1);
        chk("mid_valid_pre", valid_o, 1);
        #2 reset_i = 1;
        #1;
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_target", target_o, 0);
        chk("mid_rst_cnt", decodedCount_o, 0);
        step();
        reset_i = 0;
        step();
        chk("post_rst_ready", ready_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
